// File: rtl/gray_counter_pkg.sv
// Shared types and Gray-code helpers for the counter bank and its consumers.
// Helpers operate at GRAY_MAX_W bits; callers zero-extend and truncate.
package gray_counter_pkg;

  localparam int GRAY_MAX_W = 64;

  typedef enum logic {
    MODE_WRAP     = 1'b0,
    MODE_SATURATE = 1'b1
  } count_mode_e;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_channel.sv
// One up/down counter with its registered Gray image and limit flag.
// Gray is derived from the next binary value so both registers always agree.
module gray_counter_channel
  import gray_counter_pkg::*;
#(
  parameter int LENGTH   = 8,
  parameter int SATURATE = 0
) (
  input  logic              clk_counter,
  input  logic              reset_counter_n,
  input  logic              ce,
  input  logic              up,
  input  logic              load,
  input  logic [LENGTH-1:0] load_value,
  input  logic              clear,
  output logic [LENGTH-1:0] binary,
  output logic [LENGTH-1:0] gray,
  output logic              limit
);

  localparam count_mode_e      MODE      = (SATURATE != 0) ? MODE_SATURATE : MODE_WRAP;
  localparam logic [LENGTH-1:0] MAX_VALUE = '1;
  localparam logic [LENGTH-1:0] ONE       = LENGTH'(1);

  logic [LENGTH-1:0] binary_next;
  logic              limit_next;
  logic              at_edge;

  always_comb begin
    binary_next = binary;
    limit_next  = 1'b0;
    at_edge     = up ? (binary == MAX_VALUE) : (binary == '0);
    if (clear) begin
      binary_next = '0;
    end else if (load) begin
      binary_next = load_value;
    end else if (ce) begin
      limit_next = at_edge;
      // A blocked step in saturate mode keeps the count but still flags it.
      if (!(at_edge && (MODE == MODE_SATURATE))) begin
        binary_next = up ? (binary + ONE) : (binary - ONE);
      end
    end
  end

  always_ff @(posedge clk_counter or negedge reset_counter_n) begin
    if (!reset_counter_n) begin
      binary <= '0;
      gray   <= '0;
      limit  <= 1'b0;
    end else begin
      binary <= binary_next;
      gray   <= LENGTH'(bin2gray(GRAY_MAX_W'(binary_next)));
      limit  <= limit_next;
    end
  end

endmodule

// File: rtl/gray_counter_bank.sv
// Bank of independent Gray counters with a coherent bank-wide Gray snapshot.
// Snapshot captures the pre-update gray_out of every channel on the same edge.
module gray_counter_bank
  import gray_counter_pkg::*;
#(
  parameter int LENGTH   = 8,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0
) (
  input  logic                         clk_counter,
  input  logic                         reset_counter_n,
  input  logic [CHANNELS-1:0]          ce,
  input  logic [CHANNELS-1:0]          up,
  input  logic [CHANNELS-1:0]          load,
  input  logic [CHANNELS*LENGTH-1:0]   load_value,
  input  logic [CHANNELS-1:0]          clear,
  input  logic                         capture,
  output logic [CHANNELS*LENGTH-1:0]   binary_out,
  output logic [CHANNELS*LENGTH-1:0]   gray_out,
  output logic [CHANNELS-1:0]          limit,
  output logic [CHANNELS*LENGTH-1:0]   snapshot_gray,
  output logic                         snapshot_valid
);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
      gray_counter_channel #(
        .LENGTH   (LENGTH),
        .SATURATE (SATURATE)
      ) u_channel (
        .clk_counter     (clk_counter),
        .reset_counter_n (reset_counter_n),
        .ce              (ce[gi]),
        .up              (up[gi]),
        .load            (load[gi]),
        .load_value      (load_value[gi*LENGTH +: LENGTH]),
        .clear           (clear[gi]),
        .binary          (binary_out[gi*LENGTH +: LENGTH]),
        .gray            (gray_out[gi*LENGTH +: LENGTH]),
        .limit           (limit[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk_counter or negedge reset_counter_n) begin
    if (!reset_counter_n) begin
      snapshot_gray  <= '0;
      snapshot_valid <= 1'b0;
    end else begin
      if (capture) begin
        snapshot_gray <= gray_out;
      end
      snapshot_valid <= capture;
    end
  end

endmodule

// File: tb/tb_gray_counter_bank.sv
// Scoreboard bench: a wrap-mode and a saturate-mode bank share stimulus and are
// checked each cycle against an independent behavioural model.
module tb_gray_counter_bank;
  import gray_counter_pkg::*;

  localparam logic [3:0] GRAY_TAB [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                          4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  typedef struct packed {
    logic [15:0] wbin;
    logic [15:0] wgray;
    logic [3:0]  wlim;
    logic [15:0] wsnap;
    logic [15:0] sbin;
    logic [15:0] sgray;
    logic [3:0]  slim;
    logic [15:0] ssnap;
    logic        sv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ce = '0, up = '0, load = '0, clear = '0;
  logic [15:0] load_value = '0;
  logic        capture = 1'b0;

  logic [15:0] w_bin, w_gray, w_snap, s_bin, s_gray, s_snap;
  logic [3:0]  w_lim, s_lim;
  logic        w_sv, s_sv;

  int checks = 0;
  int failures = 0;

  exp_t        exp_q[$];
  logic [3:0]  mw [4];
  logic [3:0]  ms [4];
  logic [15:0] snap_w, snap_s;

  always #5 clk = ~clk;

  gray_counter_bank #(.LENGTH(4), .CHANNELS(4), .SATURATE(0)) u_wrap (
    .clk_counter(clk), .reset_counter_n(rst_n), .ce(ce), .up(up), .load(load),
    .load_value(load_value), .clear(clear), .capture(capture),
    .binary_out(w_bin), .gray_out(w_gray), .limit(w_lim),
    .snapshot_gray(w_snap), .snapshot_valid(w_sv)
  );

  gray_counter_bank #(.LENGTH(4), .CHANNELS(4), .SATURATE(1)) u_sat (
    .clk_counter(clk), .reset_counter_n(rst_n), .ce(ce), .up(up), .load(load),
    .load_value(load_value), .clear(clear), .capture(capture),
    .binary_out(s_bin), .gray_out(s_gray), .limit(s_lim),
    .snapshot_gray(s_snap), .snapshot_valid(s_sv)
  );

  task automatic model_reset();
    for (int ch = 0; ch < 4; ch++) begin
      mw[ch] = '0;
      ms[ch] = '0;
    end
    snap_w = '0;
    snap_s = '0;
  endtask

  task automatic next_val(input logic [3:0] v, input logic c, input logic u, input logic l,
                          input logic cl, input logic [3:0] lv, input logic sat,
                          output logic [3:0] nv, output logic lim);
    nv  = v;
    lim = 1'b0;
    if (cl)      nv = 4'd0;
    else if (l)  nv = lv;
    else if (c) begin
      if (u) begin
        if (v == 4'd15) begin lim = 1'b1; nv = sat ? 4'd15 : 4'd0; end
        else nv = v + 4'd1;
      end else begin
        if (v == 4'd0) begin lim = 1'b1; nv = sat ? 4'd0 : 4'd15; end
        else nv = v - 4'd1;
      end
    end
  endtask

  // Drive one cycle of stimulus, push the model's expectation, advance past the edge.
  task automatic step(input logic [3:0] c, input logic [3:0] u, input logic [3:0] l,
                      input logic [15:0] lv, input logic [3:0] cl, input logic cap);
    exp_t       e;
    logic [3:0] nv;
    logic       lim;
    ce = c; up = u; load = l; load_value = lv; clear = cl; capture = cap;
    if (cap) begin
      for (int ch = 0; ch < 4; ch++) begin
        snap_w[ch*4 +: 4] = GRAY_TAB[mw[ch]];
        snap_s[ch*4 +: 4] = GRAY_TAB[ms[ch]];
      end
    end
    for (int ch = 0; ch < 4; ch++) begin
      next_val(mw[ch], c[ch], u[ch], l[ch], cl[ch], lv[ch*4 +: 4], 1'b0, nv, lim);
      mw[ch] = nv; e.wlim[ch] = lim;
      next_val(ms[ch], c[ch], u[ch], l[ch], cl[ch], lv[ch*4 +: 4], 1'b1, nv, lim);
      ms[ch] = nv; e.slim[ch] = lim;
      e.wbin[ch*4 +: 4]  = mw[ch];
      e.wgray[ch*4 +: 4] = GRAY_TAB[mw[ch]];
      e.sbin[ch*4 +: 4]  = ms[ch];
      e.sgray[ch*4 +: 4] = GRAY_TAB[ms[ch]];
    end
    e.wsnap = snap_w;
    e.ssnap = snap_s;
    e.sv    = cap;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'h0, 4'h0, 4'h0, 16'h0, 4'h0, 1'b0);
    void'(exp_q.pop_front());
    checks++;
    if ({w_bin, w_gray, w_lim, w_snap, w_sv, s_bin, s_gray, s_lim, s_snap, s_sv} !== '0) begin
      failures++;
      $display("FAIL reset_idle got wrap=%h/%h/%h/%h/%b sat=%h/%h/%h/%h/%b required all zero",
               w_bin, w_gray, w_lim, w_snap, w_sv, s_bin, s_gray, s_lim, s_snap, s_sv);
    end
    $display("reset_idle checked");
  endtask

  task automatic test_wrap();
    exp_t       e;
    logic [3:0] prev_g;
    int         pulses = 0;
    step(4'h0, 4'h0, 4'h0, 16'h0, 4'hF, 1'b0);
    void'(exp_q.pop_front());
    prev_g = w_gray[3:0];
    for (int k = 1; k <= 20; k++) begin
      step(4'h1, 4'hF, 4'h0, 16'h0, 4'h0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if ({w_bin, w_gray, w_lim, w_snap, w_sv} !== {e.wbin, e.wgray, e.wlim, e.wsnap, e.sv}) begin
        failures++;
        $display("FAIL wrap_state k=%0d got bin=%h gray=%h lim=%h required bin=%h gray=%h lim=%h",
                 k, w_bin, w_gray, w_lim, e.wbin, e.wgray, e.wlim);
      end
      checks++;
      if (w_bin[3:0] !== 4'(k % 16) || w_lim[0] !== (k == 16)) begin
        failures++;
        $display("FAIL wrap_seq k=%0d got bin=%0d lim=%b required bin=%0d lim=%b",
                 k, w_bin[3:0], w_lim[0], k % 16, (k == 16));
      end
      checks++;
      if ($countones(w_gray[3:0] ^ prev_g) != 1) begin
        failures++;
        $display("FAIL wrap_onebit k=%0d got gray %h -> %h required one bit change", k, prev_g, w_gray[3:0]);
      end
      checks++;
      if ({s_bin, s_gray, s_lim} !== {e.sbin, e.sgray, e.slim}) begin
        failures++;
        $display("FAIL sat_shadow k=%0d got %h/%h/%h required %h/%h/%h",
                 k, s_bin, s_gray, s_lim, e.sbin, e.sgray, e.slim);
      end
      if (w_lim[0]) pulses++;
      prev_g = w_gray[3:0];
      $display("wrap k=%0d bin=%0d gray=%h lim=%b", k, w_bin[3:0], w_gray[3:0], w_lim[0]);
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL wrap_pulse_count got %0d required 1", pulses);
    end
  endtask

  task automatic test_saturate();
    exp_t       e;
    logic [3:0] sat_bin [6] = '{4'd15, 4'd15, 4'd15, 4'd0, 4'd0, 4'd0};
    logic       sat_lim [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    step(4'h0, 4'h0, 4'h1, 16'h000E, 4'h0, 1'b0);
    void'(exp_q.pop_front());
    for (int k = 0; k < 6; k++) begin
      if (k < 3)       step(4'h1, 4'h1, 4'h0, 16'h0, 4'h0, 1'b0);
      else if (k == 3) step(4'h0, 4'h0, 4'h0, 16'h0, 4'h1, 1'b0);
      else             step(4'h1, 4'h0, 4'h0, 16'h0, 4'h0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (s_bin[3:0] !== sat_bin[k] || s_lim[0] !== sat_lim[k] || s_gray[3:0] !== GRAY_TAB[sat_bin[k]]) begin
        failures++;
        $display("FAIL sat_seq k=%0d got bin=%0d gray=%h lim=%b required bin=%0d lim=%b",
                 k, s_bin[3:0], s_gray[3:0], s_lim[0], sat_bin[k], sat_lim[k]);
      end
      checks++;
      if ({w_bin, w_gray, w_lim, s_bin, s_gray, s_lim} !== {e.wbin, e.wgray, e.wlim, e.sbin, e.sgray, e.slim}) begin
        failures++;
        $display("FAIL sat_model k=%0d got w=%h/%h s=%h/%h required w=%h/%h s=%h/%h",
                 k, w_bin, w_lim, s_bin, s_lim, e.wbin, e.wlim, e.sbin, e.slim);
      end
      $display("sat k=%0d bin=%0d lim=%b", k, s_bin[3:0], s_lim[0]);
    end
  endtask

  task automatic test_priority();
    step(4'h1, 4'h1, 4'h1, 16'h0009, 4'h1, 1'b0);
    void'(exp_q.pop_front());
    checks++;
    if (w_bin[3:0] !== 4'd0 || s_bin[3:0] !== 4'd0 || w_lim[0] !== 1'b0) begin
      failures++;
      $display("FAIL prio_clear got w=%0d s=%0d lim=%b required 0 0 0", w_bin[3:0], s_bin[3:0], w_lim[0]);
    end
    step(4'h1, 4'h1, 4'h1, 16'h0009, 4'h0, 1'b0);
    void'(exp_q.pop_front());
    checks++;
    if (w_bin[3:0] !== 4'd9 || s_bin[3:0] !== 4'd9 || w_gray[3:0] !== 4'hD || w_lim[0] !== 1'b0 || s_lim[0] !== 1'b0) begin
      failures++;
      $display("FAIL prio_load got w=%0d gray=%h s=%0d lim=%b/%b required 9 d 9 0/0",
               w_bin[3:0], w_gray[3:0], s_bin[3:0], w_lim[0], s_lim[0]);
    end
    $display("priority checked");
  endtask

  task automatic test_capture();
    exp_t        e;
    logic        cap_prev = 1'b0;
    logic [3:0]  bin_at_cap [4];
    step(4'h0, 4'h0, 4'hF, {4'd15, 4'd10, 4'd5, 4'd0}, 4'h0, 1'b0);
    void'(exp_q.pop_front());
    for (int k = 0; k < 9; k++) begin
      logic cap;
      cap = (k == 3) || (k == 5) || (k == 6);
      if (cap) for (int ch = 0; ch < 4; ch++) bin_at_cap[ch] = mw[ch];
      step(4'hF, 4'hF, 4'h0, 16'h0, 4'h0, cap);
      e = exp_q.pop_front();
      checks++;
      if ({w_bin, w_gray, w_lim, w_snap, w_sv, s_bin, s_gray, s_lim, s_snap, s_sv} !==
          {e.wbin, e.wgray, e.wlim, e.wsnap, e.sv, e.sbin, e.sgray, e.slim, e.ssnap, e.sv}) begin
        failures++;
        $display("FAIL capture_state k=%0d got snap=%h/%h sv=%b/%b gray=%h required snap=%h/%h sv=%b gray=%h",
                 k, w_snap, s_snap, w_sv, s_sv, w_gray, e.wsnap, e.ssnap, e.sv, e.wgray);
      end
      if (cap) begin
        for (int ch = 0; ch < 4; ch++) begin
          checks++;
          if (4'(gray2bin(GRAY_MAX_W'(w_snap[ch*4 +: 4]))) !== bin_at_cap[ch]) begin
            failures++;
            $display("FAIL capture_decode k=%0d ch=%0d got %0d required %0d",
                     k, ch, 4'(gray2bin(GRAY_MAX_W'(w_snap[ch*4 +: 4]))), bin_at_cap[ch]);
          end
        end
      end
      checks++;
      if (w_sv !== cap) begin
        failures++;
        $display("FAIL capture_valid k=%0d got %b required %b (prev cap %b)", k, w_sv, cap, cap_prev);
      end
      cap_prev = cap;
      $display("capture k=%0d cap=%b snap=%h valid=%b", k, cap, w_snap, w_sv);
    end
  endtask

  task automatic test_async_reset();
    step(4'hF, 4'hF, 4'h0, 16'h0, 4'h0, 1'b1);
    void'(exp_q.pop_front());
    ce = 4'hF; up = 4'hF; capture = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({w_bin, w_gray, w_lim, w_snap, w_sv, s_bin, s_gray, s_lim, s_snap, s_sv} !== '0) begin
      failures++;
      $display("FAIL async_reset_immediate got wrap=%h/%h/%b sat=%h/%h/%b required all zero",
               w_bin, w_snap, w_sv, s_bin, s_snap, s_sv);
    end
    repeat (2) @(posedge clk);
    #1;
    capture = 1'b0; ce = '0;
    rst_n = 1'b1;
    model_reset();
    step(4'h0, 4'h0, 4'h0, 16'h0, 4'h0, 1'b0);
    void'(exp_q.pop_front());
    checks++;
    if (w_sv !== 1'b0 || s_sv !== 1'b0 || {w_bin, w_snap, w_lim, s_bin, s_snap, s_lim} !== '0) begin
      failures++;
      $display("FAIL async_reset_release got sv=%b/%b bin=%h snap=%h required all zero",
               w_sv, s_sv, w_bin, w_snap);
    end
    $display("async_reset checked");
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_priority();
    test_capture();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
